// File: rtl/rib_mailbox.sv
// -----------------------------------------------------------------------------
// rib_mailbox
//   RIB bus responder that provides a word-wide mailbox FIFO. Any master may
//   push one word per write to DATA. Each read of DATA pops the head word.
//   The block also has a STATUS/CTRL register pair, a programmable number of
//   wait states before each response, and a level interrupt that is high
//   while the FIFO holds data.
//
//   Register map (addr_i[3:2]; the interconnect has already decoded the
//   upper address bits):
//     0 DATA   : write pushes data_i, read pops the head word (0 if empty)
//     1 STATUS : [0] empty, [1] full, [2] overflow, [3] underflow,
//                [15:8] count, all other bits 0 (read-only)
//     2 CTRL   : write bit0 flushes the FIFO, bit1 clears the sticky
//                flags; reads return 0
//     3 -      : reads return 0, writes are ignored
//
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active low
//   req_i    access request from the interconnect
//   we_i     write flag, valid while req_i=1
//   addr_i   access address; only bits [3:2] are decoded
//   data_i   write data
//   data_o   read data, valid while ready_o=1; holds its value otherwise
//   ready_o  one-cycle response pulse
//   irq_o    level interrupt, 1 while the FIFO is not empty
// -----------------------------------------------------------------------------
module rib_mailbox #(
    parameter int Depth      = 8,
    parameter int WaitCycles = 1,
    parameter int MemBus     = 32,
    parameter int MemAddrBus = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [MemAddrBus-1:0] addr_i,
    input  logic [MemBus-1:0]     data_i,
    output logic [MemBus-1:0]     data_o,
    output logic                  ready_o,
    output logic                  irq_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q,  state_d;
    logic [3:0]        cnt_q,    cnt_d;
    logic [1:0]        reg_q,    reg_d;
    logic              we_q,     we_d;
    logic [MemBus-1:0] wdata_q,  wdata_d;
    logic [MemBus-1:0] rdata_q,  rdata_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;
    logic              irq_q,    irq_d;

    logic [MemBus-1:0] mem [Depth];
    logic              mem_we;

    logic              fifo_empty;
    logic              fifo_full;
    logic [1:0]        acc_reg;
    logic              acc_we;
    logic [MemBus-1:0] status_word;
    logic [MemBus-1:0] resp_word;

    // Only addr_i[3:2] carries information for this block.
    logic unused_addr;
    assign unused_addr = ^{addr_i[MemAddrBus-1:4], addr_i[1:0]};

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(Depth));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        reg_d    = reg_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        irq_d    = (count_q != '0);
        mem_we   = 1'b0;

        // With zero wait states RESP is entered straight from IDLE, before
        // the access has been captured, so the response is formed from the
        // live bus in that case.
        acc_reg = (state_q == IDLE) ? addr_i[3:2] : reg_q;
        acc_we  = (state_q == IDLE) ? we_i : we_q;

        status_word       = '0;
        status_word[0]    = fifo_empty;
        status_word[1]    = fifo_full;
        status_word[2]    = ovf_q;
        status_word[3]    = udf_q;
        status_word[15:8] = 8'(count_q);

        resp_word = '0;
        if (!acc_we) begin
            case (acc_reg)
                REG_DATA:   resp_word = fifo_empty ? '0 : mem[rd_ptr_q];
                REG_STATUS: resp_word = status_word;
                default:    resp_word = '0;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    reg_d   = addr_i[3:2];
                    we_d    = we_i;
                    wdata_d = data_i;
                    cnt_d   = 4'(WaitCycles);
                    if (WaitCycles == 0) begin
                        state_d = RESP;
                        rdata_d = resp_word;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!req_i) begin
                    // Master withdrew the request: abandon it silently.
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    rdata_d = resp_word;
                end
            end

            RESP: begin
                // The response was sampled on entry; the access takes effect
                // on the edge that leaves RESP.
                state_d = IDLE;
                if (we_q) begin
                    case (reg_q)
                        REG_DATA: begin
                            if (fifo_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                mem_we   = 1'b1;
                                wr_ptr_d = wr_ptr_q + 1'b1;
                                count_d  = count_q + 1'b1;
                            end
                        end
                        REG_CTRL: begin
                            if (wdata_q[0]) begin
                                rd_ptr_d = '0;
                                wr_ptr_d = '0;
                                count_d  = '0;
                            end
                            if (wdata_q[1]) begin
                                ovf_d = 1'b0;
                                udf_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end else if (reg_q == REG_DATA) begin
                    if (fifo_empty) begin
                        udf_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reg_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reg_q    <= reg_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            irq_q    <= irq_d;
        end
    end

    // NOTE: the storage array has no reset; a slot is only ever read after
    // it has been written, because count gates every read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= wdata_q;
        end
    end

    assign data_o  = rdata_q;
    assign ready_o = (state_q == RESP);
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_rib_mailbox.sv
// -----------------------------------------------------------------------------
// tb_rib_mailbox
//   Self-checking bench for rib_mailbox. Instance 0 runs with one wait state
//   and instance 1 with three. A queue-based mailbox model predicts every
//   read value for instance 0. Directed sequences cover ordering, overflow,
//   underflow, flags, back-to-back requests, withdrawn requests and reset.
//   These are followed by a randomized access mix.
// -----------------------------------------------------------------------------
module tb_rib_mailbox;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [0:1];
    logic        req  [0:1];
    logic        we   [0:1];
    logic [31:0] addr [0:1];
    logic [31:0] wdat [0:1];
    logic [31:0] rdat [0:1];
    logic        rdy  [0:1];
    logic        irq  [0:1];

    rib_mailbox #(.Depth(DEPTH), .WaitCycles(1), .MemBus(32), .MemAddrBus(32)) u_dut_w1 (
        .clk(clk), .rst(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .data_i(wdat[0]), .data_o(rdat[0]), .ready_o(rdy[0]), .irq_o(irq[0])
    );

    rib_mailbox #(.Depth(DEPTH), .WaitCycles(3), .MemBus(32), .MemAddrBus(32)) u_dut_w3 (
        .clk(clk), .rst(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .data_i(wdat[1]), .data_o(rdat[1]), .ready_o(rdy[1]), .irq_o(irq[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Mailbox model for instance 0: contents plus the two sticky flags.
    logic [31:0] mq[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    // Returns the read value the access produces (state before the access)
    // and then applies its effect.
    function automatic logic [31:0] model_access(input logic w, input logic [1:0] r,
                                                 input logic [31:0] wd);
        logic [31:0] st;
        st = {16'h0, 8'(mq.size()), 4'h0, m_udf, m_ovf,
              (mq.size() == DEPTH), (mq.size() == 0)};
        if (w) begin
            case (r)
                2'd0: if (mq.size() == DEPTH) m_ovf = 1'b1; else mq.push_back(wd);
                2'd2: begin
                    if (wd[0]) mq.delete();
                    if (wd[1]) begin m_ovf = 1'b0; m_udf = 1'b0; end
                end
                default: ;
            endcase
            return 32'h0;
        end
        case (r)
            2'd0: begin
                if (mq.size() == 0) begin m_udf = 1'b1; return 32'h0; end
                return mq.pop_front();
            end
            2'd1:    return st;
            default: return 32'h0;
        endcase
    endfunction

    // One bus transaction on instance d. lat counts clock edges from the
    // edge that first samples req_i to the edge after which ready_o is seen.
    task automatic do_access(input int d, input logic w, input logic [1:0] r,
                             input logic [31:0] wd, output logic [31:0] rd, output int lat);
        logic [31:0] ra;
        @(posedge clk); #1;
        ra       = $urandom();
        ra[3:2]  = r;
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = ra;
        wdat[d]  = wd;
        lat      = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rdy[d] && lat < 40);
        rd     = rdat[d];
        req[d] = 1'b0;
    endtask

    // Instance 0 access, checked for latency and against the model.
    task automatic xact(input logic w, input logic [1:0] r, input logic [31:0] wd,
                        input string tag, output logic [31:0] rd);
        int          lat;
        logic [31:0] exp;
        do_access(0, w, r, wd, rd, lat);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        exp = model_access(w, r, wd);
        if (!w) check(tag, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          gap;
        logic        seen;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdat[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'h0);
            check($sformatf("rst_data%0d", i), rdat[i], 32'h0);
            check($sformatf("rst_irq%0d", i), 32'(irq[i]), 32'h0);
        end
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        // ---- Single write, irq timing, STATUS ----
        xact(1'b1, 2'd0, 32'hDEAD_BEEF, "wr_deadbeef", rd);
        @(posedge clk); #1;
        check("irq_at_commit", 32'(irq[0]), 32'h0);
        @(posedge clk); #1;
        check("irq_after_commit", 32'(irq[0]), 32'h1);
        xact(1'b0, 2'd1, 32'h0, "status_one", rd);
        check("status_one_const", rd, 32'h0000_0100);
        xact(1'b0, 2'd0, 32'h0, "pop_deadbeef", rd);

        // ---- Ordering ----
        xact(1'b1, 2'd0, 32'h11, "push11", rd);
        xact(1'b1, 2'd0, 32'h22, "push22", rd);
        xact(1'b1, 2'd0, 32'h33, "push33", rd);
        xact(1'b0, 2'd0, 32'h0, "pop11", rd); check("pop11_const", rd, 32'h11);
        xact(1'b0, 2'd0, 32'h0, "pop22", rd); check("pop22_const", rd, 32'h22);
        xact(1'b0, 2'd0, 32'h0, "pop33", rd); check("pop33_const", rd, 32'h33);
        xact(1'b0, 2'd1, 32'h0, "status_empty", rd);
        check("status_empty_const", rd, 32'h0000_0001);

        // ---- Overflow ----
        for (int i = 1; i <= 9; i++) xact(1'b1, 2'd0, 32'(i), "push_fill", rd);
        xact(1'b0, 2'd1, 32'h0, "status_full", rd);
        check("status_full_const", rd, 32'h0000_0806);
        for (int i = 1; i <= 8; i++) begin
            xact(1'b0, 2'd0, 32'h0, "pop_fill", rd);
            check($sformatf("pop_fill%0d_const", i), rd, 32'(i));
        end
        xact(1'b1, 2'd2, 32'h2, "ctrl_clr", rd);

        // ---- Underflow, then flush+clear ----
        xact(1'b0, 2'd0, 32'h0, "pop_empty", rd);
        check("pop_empty_const", rd, 32'h0);
        xact(1'b0, 2'd1, 32'h0, "status_udf", rd);
        check("status_udf_const", rd, 32'h0000_0009);
        xact(1'b1, 2'd2, 32'h3, "ctrl_both", rd);
        xact(1'b0, 2'd1, 32'h0, "status_cleared", rd);
        check("status_cleared_const", rd, 32'h0000_0001);
        xact(1'b0, 2'd2, 32'h0, "ctrl_read", rd);
        xact(1'b0, 2'd3, 32'h0, "rsvd_read", rd);

        // ---- req_i held across two writes ----
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0; wdat[0] = 32'hA;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!rdy[0] && lat < 40);
        check("hold_first_lat", 32'(lat), 32'd2);
        wdat[0] = 32'hB;
        gap = 0;
        do begin @(posedge clk); #1; gap++; end while (!rdy[0] && gap < 40);
        check("hold_gap", 32'(gap), 32'd3);
        req[0] = 1'b0;
        void'(model_access(1'b1, 2'd0, 32'hA));
        void'(model_access(1'b1, 2'd0, 32'hB));
        xact(1'b0, 2'd1, 32'h0, "hold_status", rd);
        check("hold_status_const", rd, 32'h0000_0200);
        xact(1'b0, 2'd0, 32'h0, "hold_popA", rd); check("hold_popA_const", rd, 32'hA);
        xact(1'b0, 2'd0, 32'h0, "hold_popB", rd); check("hold_popB_const", rd, 32'hB);

        // ---- Instance 1 (three wait states): withdrawn request ----
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0; wdat[1] = 32'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req[1] = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (rdy[1]) seen = 1'b1; end
        check("w3_abort_ready", 32'(seen), 32'h0);
        do_access(1, 1'b0, 2'd1, 32'h0, rd, lat);
        check("w3_abort_status", rd, 32'h0000_0001);
        check("w3_read_lat", 32'(lat), 32'd4);
        do_access(1, 1'b1, 2'd0, 32'h55, rd, lat);
        check("w3_write_lat", 32'(lat), 32'd4);
        do_access(1, 1'b0, 2'd1, 32'h0, rd, lat);
        check("w3_status_one", rd, 32'h0000_0100);

        // ---- Instance 1: reset during WAIT ----
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0; wdat[1] = 32'h99;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        req[1] = 1'b0;
        #1;
        check("w3_rst_ready", 32'(rdy[1]), 32'h0);
        check("w3_rst_data", rdat[1], 32'h0);
        check("w3_rst_irq", 32'(irq[1]), 32'h0);
        @(posedge clk); #1;
        rst[1] = 1'b1;
        do_access(1, 1'b0, 2'd1, 32'h0, rd, lat);
        check("w3_after_rst_status", rd, 32'h0000_0001);

        // ---- Randomized mix on instance 0 ----
        for (int i = 0; i < 150; i++) begin
            logic        w;
            logic [1:0]  r;
            logic [31:0] wd;
            int          sel;
            sel = $urandom_range(0, 9);
            r   = (sel < 5) ? 2'd0 : (sel < 8) ? 2'd1 : (sel == 8) ? 2'd2 : 2'd3;
            w   = ($urandom_range(0, 9) < 6);
            wd  = $urandom();
            if (r == 2'd2 && $urandom_range(0, 3) != 0) wd[1:0] = 2'b00;
            xact(w, r, wd, "rnd", rd);
            @(posedge clk); #1;
            @(posedge clk); #1;
            check("rnd_irq", 32'(irq[0]), 32'(mq.size() != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rib_mailbox.md
Name: rib_mailbox

Overview:
- RIB bus responder (slave) for the req/ready-handshaked slave slots (slave 6/7 class).
- Provides a word-wide mailbox FIFO, one-word writable from any master, drained by reads.
- Also provides status/control registers, programmable wait-state insertion and a not-empty interrupt.
- Sits behind the RIB interconnect; the interconnect has already decoded addr[31:28], so this block decodes only addr[3:2].

Parameters:
- Depth, 8, FIFO depth in words; power of two, 2..128.
- WaitCycles, 1, extra cycles between request capture and response; 0..15.
- MemBus, 32, data width.
- MemAddrBus, 32, address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req_i  in  1  access request from the RIB interconnect
- we_i  in  1  write flag, valid while req_i=1
- addr_i  in  MemAddrBus  access address; only [3:2] decoded
- data_i  in  MemBus  write data
- data_o  out  MemBus  read data, valid while ready_o=1
- ready_o  out  1  one-cycle response pulse
- irq_o  out  1  level interrupt, 1 while FIFO not empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: ready_o=0, data_o=0, irq_o=0. FIFO pointers, count, overflow and underflow flags are all 0. FSM=IDLE.
- Register map (addr[3:2]):
  - 0 DATA: write pushes data_i; read pops the head word.
  - 1 STATUS (read-only): [0] empty, [1] full, [2] overflow (sticky), [3] underflow (sticky), [15:8] count, other bits 0.
  - 2 CTRL (write-only): bit0=1 flushes pointers/count; bit1=1 clears overflow/underflow; reads return 0.
  - 3 reserved: reads return 0, writes ignored.
- Master contract: holds addr_i/we_i/data_i stable while req_i=1 and ready_o=0.
- FSM states:
  - IDLE: if req_i=1, capture addr/we/data and load wait counter with WaitCycles. Go to RESP if WaitCycles=0, else to WAIT.
  - WAIT: decrement the counter; go to RESP on the edge where the counter equals 1. If req_i=0 in WAIT, go to IDLE with no side effect and no ready_o.
  - RESP: ready_o=1 for exactly this cycle. data_o is registered on entry to RESP: the FIFO head, STATUS, or 0. Side effects commit on the RESP-exit edge. The next state is always IDLE.
- Latency: with req_i first sampled high at edge N, ready_o is high in the cycle after edge N+WaitCycles. Minimum is 1 cycle; WaitCycles=1 gives 2 cycles.
- Back-to-back requests: because RESP always returns to IDLE, there is at least one idle cycle between responses. req_i still high in IDLE starts a new transaction.
- Boundary conditions:
  - Push when full: data dropped, overflow←1, pointers unchanged.
  - Pop when empty: data_o=0, underflow←1, pointers unchanged.
  - Pointers wrap modulo Depth; count width is log2(Depth)+1.
  - CTRL write with bits 0 and 1 both set: flush and clear both happen on the same edge.
  - STATUS read reports state as of RESP entry; the pending access has not yet committed.
- irq_o = registered (count!=0). It follows count one cycle after the commit edge.
- rst asserted mid-transaction: immediate return to reset values. The in-flight access is lost with no push/pop.
- data_o holds its last response value outside RESP. The interconnect ignores it because ready_o=0.

Test Plan:
- WaitCycles=1; write DATA=0xDEADBEEF → ready_o 2 cycles after req; STATUS read=0x00000100; irq_o=1 one cycle after the write commit.
- Push 0x11, 0x22, 0x33; pop three times → data_o 0x11, 0x22, 0x33 in order; STATUS afterwards=0x00000001.
- Depth=8: push 9 words 0x1..0x9 → STATUS=0x00000806 (count 8, full, overflow); pops return 0x1..0x8.
- Pop on empty → data_o=0; STATUS=0x00000009. Then CTRL write 0x3 → STATUS=0x00000001.
- WaitCycles=3: drop req_i during WAIT on a DATA write → no ready_o, count stays 0. Also assert rst in WAIT → all outputs 0 on the next sample.
- Hold req_i=1 across two DATA writes (0xA, 0xB) → two ready_o pulses separated by IDLE+WAIT; count=2 with no lost word.
